ds_width_packer: RTL

DataStream width upconverter that packs RATIO consecutive narrow words into one wide word. It sits directly upstream of the single-clock DataStream FIFO: it collects narrow beats from a source and presents full-width words to the FIFO's inbound port. Both sides use the same valid/ready DataStream handshake, and the packer sustains one narrow beat per clock.

---
 rtl/ds_width_packer.sv | 90 +++++++++
 1 files changed

// File: rtl/ds_width_packer.sv
// DataStream width upconverter: packs RATIO narrow beats into one wide word.
// Optional early close on end-of-packet: define DS_WIDTH_PACKER_EOP_EN.
module ds_width_packer #(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned RATIO  = 4,
    localparam int unsigned OWIDTH = IWIDTH * RATIO,
    localparam int unsigned CWIDTH = $clog2(RATIO + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IWIDTH-1:0] i_dat,
    input  logic              i_val,
    output logic              i_rdy,
    output logic [OWIDTH-1:0] o_dat,
    output logic              o_val,
    input  logic              o_rdy
`ifdef DS_WIDTH_PACKER_EOP_EN
    ,
    input  logic              i_eop,
    output logic              o_eop,
    output logic [CWIDTH-1:0] o_cnt
`endif
);

    localparam logic [CWIDTH-1:0] LAST = CWIDTH'(RATIO - 1);

    logic [OWIDTH-1:0] acc;
    logic [OWIDTH-1:0] word;
    logic [CWIDTH-1:0] cnt;
    logic              closing;
    logic              closing_pending;
    logic              in_fire;

    always_comb begin
        closing         = (cnt == LAST);
        closing_pending = (cnt == LAST);
`ifdef DS_WIDTH_PACKER_EOP_EN
        // any beat may carry i_eop, so a close is always possible
        closing         = closing | i_eop;
        closing_pending = 1'b1;
`endif
        i_rdy   = ~(closing_pending & o_val & ~o_rdy);
        in_fire = i_val & i_rdy;
    end

    // unwritten lanes of acc are always zero, so only lane cnt is replaced
    always_comb begin
        word = acc;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt == CWIDTH'(k)) begin
                word[k*IWIDTH +: IWIDTH] = i_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            o_dat <= '0;
            o_val <= 1'b0;
`ifdef DS_WIDTH_PACKER_EOP_EN
            o_eop <= 1'b0;
            o_cnt <= '0;
`endif
        end else begin
            if (in_fire) begin
                if (closing) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= word;
                    cnt <= cnt + CWIDTH'(1);
                end
            end
            // a new word load takes priority over draining the old one
            if (in_fire && closing) begin
                o_dat <= word;
                o_val <= 1'b1;
`ifdef DS_WIDTH_PACKER_EOP_EN
                o_eop <= i_eop;
                o_cnt <= cnt + CWIDTH'(1);
`endif
            end else if (o_val && o_rdy) begin
                o_val <= 1'b0;
            end
        end
    end

endmodule
